// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: control-bit positions, ALUOp codes, opcodes, FSM encoding and forwarding helper for the execute stage
package ex_stage_pkg;
    localparam int C_REG2LOC = 8;
    localparam int C_ALUSRC  = 7;
    localparam int C_WB_HI   = 6;
    localparam int C_WB_LO   = 2;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASS  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_MUL = 11'b10011011000;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // EX/MEM result wins over MEM/WB; XZR always reads as its register-file value
    function automatic logic [63:0] fwd(
        input logic [4:0]  src,
        input logic [63:0] reg_val,
        input logic        ex_we,
        input logic [4:0]  ex_rd,
        input logic [63:0] ex_val,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [63:0] wb_val
    );
        return (src != XZR && ex_we && ex_rd == src) ? ex_val :
               (src != XZR && wb_we && wb_rd == src) ? wb_val : reg_val;
    endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, forwarding sources, hazard controls and EX/MEM outputs of the execute stage
interface ex_stage_if;
    logic [8:0]  ctrl_in;
    logic [63:0] pc_in;
    logic [63:0] rd_data_1_in;
    logic [63:0] rd_data_2_in;
    logic [63:0] sign_extend_in;
    logic [10:0] opcode_in;
    logic [4:0]  rn_in;
    logic [4:0]  rm_in;
    logic [4:0]  rd_in;
    logic        exmem_regwrite;
    logic        memwb_regwrite;
    logic [4:0]  exmem_rd;
    logic [4:0]  memwb_rd;
    logic [63:0] exmem_data;
    logic [63:0] memwb_data;
    logic        flush_in;
    logic        stall_out;
    logic [4:0]  ctrl_out;
    logic [63:0] alu_result_out;
    logic [63:0] wr_data_out;
    logic [63:0] branch_target_out;
    logic        zero_out;
    logic [4:0]  rd_out;

    modport master (
        output ctrl_in, pc_in, rd_data_1_in, rd_data_2_in, sign_extend_in, opcode_in,
               rn_in, rm_in, rd_in, exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
               exmem_data, memwb_data, flush_in,
        input  stall_out, ctrl_out, alu_result_out, wr_data_out, branch_target_out, zero_out, rd_out
    );

    modport slave (
        input  ctrl_in, pc_in, rd_data_1_in, rd_data_2_in, sign_extend_in, opcode_in,
               rn_in, rm_in, rd_in, exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
               exmem_data, memwb_data, flush_in,
        output stall_out, ctrl_out, alu_result_out, wr_data_out, branch_target_out, zero_out, rd_out
    );
endinterface

// File: rtl/ex_stage_mul_iter.sv
// ex_stage_mul_iter: shift-add multiplier retiring MUL_BITS multiplier bits per cycle, low 64 product bits
module ex_stage_mul_iter #(
    parameter int MUL_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    localparam int N  = 64 / MUL_BITS;
    localparam int CW = $clog2(N);

    logic [63:0]   mcand, mplier, acc;
    logic [CW-1:0] cnt;

    function automatic logic [63:0] step(input logic [63:0] acc_in, input logic [63:0] mc, input logic [63:0] mp);
        logic [63:0] s;
        s = acc_in;
        for (int i = 0; i < MUL_BITS; i++)
            if (mp[i]) s = s + (mc << i);
        return s;
    endfunction

    assign done    = busy && cnt == '0;
    assign product = acc;

    // The first partial product is taken at start, so the last one lands as cnt reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(N - 1);
            acc    <= step('0, a, b);
            mcand  <= a << MUL_BITS;
            mplier <= b >> MUL_BITS;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt    <= cnt - 1'b1;
                acc    <= step(acc, mcand, mplier);
                mcand  <= mcand << MUL_BITS;
                mplier <= mplier >> MUL_BITS;
            end
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: LEGv8 execute stage with forwarding, ALU, branch adder, iterative MUL sequencer and EX/MEM register
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_BITS = 1
) (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    state_t      state, state_nxt;
    logic [63:0] a, b, alu_b, rtype_res, alu_res, product, res;
    logic [63:0] hold_pc, hold_se, hold_b;
    logic [4:0]  hold_ctrl, hold_rd;
    logic [1:0]  aluop;
    logic        is_mul, mul_start, mul_busy, mul_done, load, sel_hold;
    logic        unused_reg2loc;

    assign unused_reg2loc = bus.ctrl_in[C_REG2LOC];

    assign a = fwd(bus.rn_in, bus.rd_data_1_in, bus.exmem_regwrite, bus.exmem_rd, bus.exmem_data,
                   bus.memwb_regwrite, bus.memwb_rd, bus.memwb_data);
    assign b = fwd(bus.rm_in, bus.rd_data_2_in, bus.exmem_regwrite, bus.exmem_rd, bus.exmem_data,
                   bus.memwb_regwrite, bus.memwb_rd, bus.memwb_data);

    assign aluop     = bus.ctrl_in[1:0];
    assign alu_b     = bus.ctrl_in[C_ALUSRC] ? bus.sign_extend_in : b;
    assign is_mul    = aluop == ALUOP_RTYPE && bus.opcode_in == OP_MUL;
    assign rtype_res = bus.opcode_in == OP_ADD ? a + alu_b :
                       bus.opcode_in == OP_SUB ? a - alu_b :
                       bus.opcode_in == OP_AND ? a & alu_b :
                       bus.opcode_in == OP_ORR ? a | alu_b : '0;
    assign alu_res   = aluop == ALUOP_ADD   ? a + alu_b :
                       aluop == ALUOP_PASS  ? alu_b :
                       aluop == ALUOP_RTYPE ? rtype_res : '0;

    assign sel_hold = state == BUSY;
    assign res      = sel_hold ? product : alu_res;

    ex_stage_mul_iter #(.MUL_BITS(MUL_BITS)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .abort   (bus.flush_in),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // Sequencer: flush overrides everything; a MUL stalls upstream until its product is ready
    always_comb begin
        state_nxt     = state;
        mul_start     = 1'b0;
        load          = 1'b0;
        bus.stall_out = 1'b0;
        if (bus.flush_in) begin
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            load          = !is_mul;
            mul_start     = is_mul;
            bus.stall_out = is_mul && rst_n;
            state_nxt     = is_mul ? BUSY : IDLE;
        end else begin
            load          = mul_done;
            bus.stall_out = mul_busy && !mul_done;
            state_nxt     = mul_done ? IDLE : BUSY;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Keep the MUL's own context because ID/EX moves on while the product is built
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_ctrl <= '0;
            hold_rd   <= '0;
            hold_pc   <= '0;
            hold_se   <= '0;
            hold_b    <= '0;
        end else if (mul_start) begin
            hold_ctrl <= bus.ctrl_in[C_WB_HI:C_WB_LO];
            hold_rd   <= bus.rd_in;
            hold_pc   <= bus.pc_in;
            hold_se   <= bus.sign_extend_in;
            hold_b    <= b;
        end
    end

    // EX/MEM register: a bubble clears only the control bits and leaves data untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ctrl_out          <= '0;
            bus.alu_result_out    <= '0;
            bus.wr_data_out       <= '0;
            bus.branch_target_out <= '0;
            bus.zero_out          <= 1'b0;
            bus.rd_out            <= '0;
        end else begin
            bus.ctrl_out <= !load ? '0 : sel_hold ? hold_ctrl : bus.ctrl_in[C_WB_HI:C_WB_LO];
            if (load) begin
                bus.alu_result_out    <= res;
                bus.zero_out          <= res == '0;
                bus.wr_data_out       <= sel_hold ? hold_b : b;
                bus.rd_out            <= sel_hold ? hold_rd : bus.rd_in;
                bus.branch_target_out <= (sel_hold ? hold_pc : bus.pc_in) +
                                         ((sel_hold ? hold_se : bus.sign_extend_in) << 2);
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with a scoreboard queue checked by an independent EX/MEM monitor
module tb_ex_stage;
    localparam logic [8:0]  R_TYPE = 9'b000100010;
    localparam logic [8:0]  LDUR   = 9'b011110000;
    localparam logic [8:0]  CBZ    = 9'b100000101;
    localparam logic [10:0] ADD    = 11'b10001011000;
    localparam logic [10:0] SUB    = 11'b11001011000;
    localparam logic [10:0] ANDOP  = 11'b10001010000;
    localparam logic [10:0] ORR    = 11'b10101010000;
    localparam logic [10:0] MUL    = 11'b10011011000;

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] wd;
        logic [63:0] bt;
        logic        z;
        logic [4:0]  rd;
        logic [4:0]  ctl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    exp_t e;

    ex_stage_if bus();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Monitor: every non-bubble EX/MEM load must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.ctrl_out != 5'd0) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL extra_output: ctrl=%b res=%h rd=%0d with nothing expected",
                         bus.ctrl_out, bus.alu_result_out, bus.rd_out);
            end else begin
                e = q.pop_front();
                if ({bus.alu_result_out, bus.wr_data_out, bus.branch_target_out, bus.zero_out, bus.rd_out, bus.ctrl_out} !== e) begin
                    bad++;
                    $display("FAIL exmem: got res=%h wd=%h bt=%h z=%b rd=%0d ctl=%b want res=%h wd=%h bt=%h z=%b rd=%0d ctl=%b",
                             bus.alu_result_out, bus.wr_data_out, bus.branch_target_out, bus.zero_out, bus.rd_out,
                             bus.ctrl_out, e.res, e.wd, e.bt, e.z, e.rd, e.ctl);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step;
        tick;
        #5;
        check("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic push(input logic [63:0] res, input logic [63:0] wd, input logic [63:0] bt,
                        input logic z, input logic [4:0] rd, input logic [4:0] ctl);
        q.push_back('{res: res, wd: wd, bt: bt, z: z, rd: rd, ctl: ctl});
    endtask

    task automatic issue(input logic [8:0] c, input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] se, input logic [63:0] pc);
        bus.ctrl_in        = c;
        bus.opcode_in      = op;
        bus.rn_in          = rn;
        bus.rm_in          = rm;
        bus.rd_in          = rd;
        bus.rd_data_1_in   = a;
        bus.rd_data_2_in   = b;
        bus.sign_extend_in = se;
        bus.pc_in          = pc;
        #1;
    endtask

    task automatic fwd_set(input logic ew, input logic [4:0] erd, input logic [63:0] ed,
                           input logic ww, input logic [4:0] wrd, input logic [63:0] wd);
        bus.exmem_regwrite = ew;
        bus.exmem_rd       = erd;
        bus.exmem_data     = ed;
        bus.memwb_regwrite = ww;
        bus.memwb_rd       = wrd;
        bus.memwb_data     = wd;
    endtask

    task automatic nop;
        issue(9'd0, 11'd0, 5'd1, 5'd2, 5'd7, 64'h77, 64'd0, 64'd0, 64'h500);
    endtask

    task automatic mul_run(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] want, input logic [4:0] rd, input logic drain);
        int n = 0;
        push(want, b, 64'h308, want == 64'd0, rd, 5'b01000);
        issue(R_TYPE, MUL, 5'd3, 5'd4, rd, a, b, 64'd2, 64'h300);
        while (bus.stall_out && n < 200) begin
            tick;
            n++;
            if (drain) fwd_set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        end
        check({name, "_stall_cycles"}, 64'(n), 64'd64);
        step;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush_in = 1'b0;
        fwd_set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        nop;
        repeat (2) tick;
        check("rst_res", bus.alu_result_out, 64'd0);
        check("rst_ctrl", 64'(bus.ctrl_out), 64'd0);
        check("rst_stall", 64'(bus.stall_out), 64'd0);
        check("rst_bt", bus.branch_target_out, 64'd0);
        rst_n = 1'b1;

        push(64'd12, 64'd7, 64'h44, 1'b0, 5'd1, 5'b01000);
        issue(R_TYPE, ADD, 5'd1, 5'd2, 5'd1, 64'd5, 64'd7, 64'd1, 64'h40);
        step;

        fwd_set(1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB);
        push(64'hAB, 64'd1, 64'd0, 1'b0, 5'd2, 5'b01000);
        issue(R_TYPE, ADD, 5'd3, 5'd4, 5'd2, 64'h11, 64'd1, 64'd0, 64'd0);
        step;

        fwd_set(1'b0, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB);
        push(64'hBC, 64'd1, 64'd0, 1'b0, 5'd2, 5'b01000);
        issue(R_TYPE, ADD, 5'd3, 5'd4, 5'd2, 64'h11, 64'd1, 64'd0, 64'd0);
        step;

        fwd_set(1'b1, 5'd31, 64'hAA, 1'b1, 5'd31, 64'hBB);
        push(64'h12, 64'd1, 64'd0, 1'b0, 5'd2, 5'b01000);
        issue(R_TYPE, ADD, 5'd31, 5'd4, 5'd2, 64'h11, 64'd1, 64'd0, 64'd0);
        step;

        fwd_set(1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB);
        push(64'hBA, 64'hAA, 64'd0, 1'b0, 5'd2, 5'b01000);
        issue(R_TYPE, ADD, 5'd1, 5'd3, 5'd2, 64'h10, 64'h77, 64'd0, 64'd0);
        step;

        fwd_set(1'b1, 5'd5, 64'hAA, 1'b1, 5'd3, 64'hBB);
        push(64'hCB, 64'hBB, 64'd0, 1'b0, 5'd2, 5'b01000);
        issue(R_TYPE, ADD, 5'd1, 5'd3, 5'd2, 64'h10, 64'h77, 64'd0, 64'd0);
        step;
        fwd_set(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

        push(64'd0, 64'd20, 64'd0, 1'b1, 5'd3, 5'b01000);
        issue(R_TYPE, SUB, 5'd1, 5'd2, 5'd3, 64'd20, 64'd20, 64'd0, 64'd0);
        step;

        push(64'hF000, 64'hFF00, 64'd0, 1'b0, 5'd3, 5'b01000);
        issue(R_TYPE, ANDOP, 5'd1, 5'd2, 5'd3, 64'hF0F0, 64'hFF00, 64'd0, 64'd0);
        step;

        push(64'hFFFF, 64'h0F0F, 64'd0, 1'b0, 5'd3, 5'b01000);
        issue(R_TYPE, ORR, 5'd1, 5'd2, 5'd3, 64'hF0F0, 64'h0F0F, 64'd0, 64'd0);
        step;

        push(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 5'd3, 5'b01000);
        issue(R_TYPE, SUB, 5'd1, 5'd2, 5'd3, 64'd0, 64'd1, 64'd0, 64'd0);
        step;

        push(64'h108, 64'h55, 64'h220, 1'b0, 5'd4, 5'b11100);
        issue(LDUR, 11'b11111000010, 5'd1, 5'd2, 5'd4, 64'h100, 64'h55, 64'd8, 64'h200);
        step;

        push(64'd0, 64'd0, 64'h110, 1'b1, 5'd0, 5'b00001);
        issue(CBZ, 11'b10110100000, 5'd0, 5'd1, 5'd0, 64'h999, 64'd0, 64'd4, 64'h100);
        step;

        push(64'd5, 64'd5, 64'hFC, 1'b0, 5'd0, 5'b00001);
        issue(CBZ, 11'b10110100000, 5'd0, 5'd1, 5'd0, 64'h999, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100);
        step;

        push(64'd0, 64'd4, 64'd0, 1'b1, 5'd5, 5'b01000);
        issue(R_TYPE, 11'b11111111111, 5'd1, 5'd2, 5'd5, 64'd3, 64'd4, 64'd0, 64'd0);
        step;

        bus.flush_in = 1'b1;
        issue(R_TYPE, ADD, 5'd1, 5'd2, 5'd6, 64'd1, 64'd1, 64'd0, 64'd0);
        check("flush_add_stall", 64'(bus.stall_out), 64'd0);
        step;
        bus.flush_in = 1'b0;
        check("flush_add_ctrl", 64'(bus.ctrl_out), 64'd0);
        check("flush_add_held", bus.alu_result_out, 64'd0);

        bus.flush_in = 1'b1;
        issue(R_TYPE, MUL, 5'd1, 5'd2, 5'd6, 64'd2, 64'd2, 64'd0, 64'd0);
        check("flush_mul_stall", 64'(bus.stall_out), 64'd0);
        step;
        bus.flush_in = 1'b0;
        nop;
        check("flush_mul_idle", 64'(bus.stall_out), 64'd0);
        step;

        mul_run("mul_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9, 1'b0);
        mul_run("mul_b2b", 64'd6, 64'd7, 64'd42, 5'd10, 1'b0);
        fwd_set(1'b1, 5'd3, 64'h10, 1'b0, 5'd0, 64'd0);
        mul_run("mul_drain", 64'hDEAD, 64'h10, 64'h100, 5'd11, 1'b1);

        issue(R_TYPE, MUL, 5'd1, 5'd2, 5'd11, 64'd2, 64'd3, 64'd0, 64'd0);
        repeat (54) tick;
        check("busy_pre_flush_stall", 64'(bus.stall_out), 64'd1);
        bus.flush_in = 1'b1;
        #1;
        check("busy_flush_stall", 64'(bus.stall_out), 64'd0);
        step;
        bus.flush_in = 1'b0;
        check("busy_flush_ctrl", 64'(bus.ctrl_out), 64'd0);
        push(64'd3, 64'd2, 64'd0, 1'b0, 5'd12, 5'b01000);
        issue(R_TYPE, ADD, 5'd1, 5'd2, 5'd12, 64'd1, 64'd2, 64'd0, 64'd0);
        check("after_flush_stall", 64'(bus.stall_out), 64'd0);
        step;
        nop;
        repeat (70) tick;
        check("no_stray_product", 64'(q.size()), 64'd0);

        issue(R_TYPE, MUL, 5'd1, 5'd2, 5'd13, 64'd5, 64'd5, 64'd0, 64'd0);
        repeat (20) tick;
        rst_n = 1'b0;
        #1;
        check("rst_mid_res", bus.alu_result_out, 64'd0);
        check("rst_mid_rd", 64'(bus.rd_out), 64'd0);
        check("rst_mid_bt", bus.branch_target_out, 64'd0);
        check("rst_mid_stall", 64'(bus.stall_out), 64'd0);
        tick;
        rst_n = 1'b1;
        mul_run("mul_after_rst", 64'd5, 64'd5, 64'd25, 5'd13, 1'b0);

        nop;
        step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
